// File: rtl/signature_reader_pkg.sv
// signature_reader_pkg: data-memory bus request/response types shared by the signature reader and its harness
package signature_reader_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

endpackage

// File: rtl/signature_reader.sv
// signature_reader: walks the signature word range on the data-memory bus and streams each word out on a valid/ready port
module signature_reader
    import signature_reader_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       sig_begin,
    input  logic [31:0]       sig_end,
    input  mem_out_type       dmem_out,
    output mem_in_type        dmem_in,
    output logic              sig_valid,
    output logic [31:0]       sig_data,
    input  logic              sig_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic [2:0] {IDLE, REQ, OUT, FIN, ERR} sig_rd_state_t;

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    sig_rd_state_t    state_q, state_d;
    logic [29:0]      addr_q, addr_d;
    logic [29:0]      end_q, end_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             empty;

    // Byte offsets inside a word are dropped before comparing the range ends.
    assign empty = (sig_end >> 2) < (sig_begin >> 2);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = sig_begin[31:2];
                end_d   = sig_end[31:2];
                cnt_d   = '0;
                err_d   = 1'b0;
                tmo_d   = '0;
                state_d = empty ? FIN : REQ;
            end
            REQ: if (dmem_out.mem_ready) begin
                data_d  = dmem_out.mem_rdata;
                state_d = OUT;
            end else if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                state_d = ERR;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            OUT: if (sig_ready) begin
                cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
                tmo_d   = '0;
                addr_d  = addr_q == end_q ? addr_q : addr_q + 1'b1;
                state_d = addr_q == end_q ? FIN : REQ;
            end
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign dmem_in = '{
        mem_valid: state_q == REQ,
        mem_instr: 1'b0,
        mem_addr:  {addr_q, 2'b00},
        mem_wdata: 32'h0,
        mem_wstrb: 4'h0
    };

    assign sig_valid = state_q == OUT;
    assign sig_data  = data_q;
    assign busy      = state_q inside {REQ, OUT, FIN};
    assign done      = state_q == FIN;
    assign err       = err_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_signature_reader.sv
// tb_signature_reader: directed vectors plus multi-cycle corner sequences against a wait-state memory model
module tb_signature_reader;
    import signature_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sig_ready = 1'b1;
    logic [31:0] sig_begin = '0;
    logic [31:0] sig_end = '0;
    mem_out_type dmem_out = '0;
    mem_in_type  dmem_in;
    logic        sig_valid, busy, done, err;
    logic [31:0] sig_data;
    logic [15:0] word_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    signature_reader #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sig_begin(sig_begin), .sig_end(sig_end),
        .dmem_out(dmem_out), .dmem_in(dmem_in), .sig_valid(sig_valid), .sig_data(sig_data),
        .sig_ready(sig_ready), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a - 32'h8000_2000) >> 2;
    endfunction

    // Memory: 0..3 random wait cycles per read, optional stall region, noise on mem_ready while idle.
    logic        stall_en = 1'b0;
    logic [31:0] stall_at = '0;
    int          wait_left = 0;
    initial forever begin
        @(posedge clk); #1;
        if (dmem_in.mem_valid) begin
            if (stall_en && dmem_in.mem_addr >= stall_at) dmem_out = '0;
            else if (wait_left == 0) begin
                dmem_out  = '{1'b1, mem_word(dmem_in.mem_addr)};
                wait_left = $urandom_range(0, 3);
            end else begin
                dmem_out = '0;
                wait_left--;
            end
        end else dmem_out = '{1'($urandom_range(0, 1)), 32'hDEAD_BEEF};
    end

    logic [31:0] req_q[$];
    logic [31:0] out_q[$];
    int          nreq = 0, ndone = 0, hold_bad = 0;
    logic        mon_off = 1'b0;
    logic        pv = 0, pr = 0, pmv = 0, pmr = 0;
    logic [31:0] pd = '0, pa = '0;
    initial forever begin
        @(negedge clk); #1;
        if (!mon_off) begin
            if (pv && !pr && (!sig_valid || sig_data != pd)) hold_bad++;
            if (pmv && !pmr && !err && (!dmem_in.mem_valid || dmem_in.mem_addr != pa)) hold_bad++;
            if (dmem_in.mem_valid && !pmv) nreq++;
            if (dmem_in.mem_valid && dmem_out.mem_ready) req_q.push_back(dmem_in.mem_addr);
            if (sig_valid && sig_ready) out_q.push_back(sig_data);
            if (done) ndone++;
        end
        pv  = sig_valid;
        pr  = sig_ready;
        pd  = sig_data;
        pmv = dmem_in.mem_valid;
        pmr = dmem_out.mem_ready;
        pa  = dmem_in.mem_addr;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic kick(input logic [31:0] b, input logic [31:0] e);
        req_q.delete();
        out_q.delete();
        nreq = 0;
        sig_begin = b;
        sig_end = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic got);
        lat = 1;
        while (!done && !err && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        got = done;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle(input string p);
        chk({p, " mem_valid"}, dmem_in.mem_valid, 0);
        chk({p, " mem_addr"}, dmem_in.mem_addr, 0);
        chk({p, " mem_const"}, {dmem_in.mem_instr, dmem_in.mem_wdata, dmem_in.mem_wstrb}, 0);
        chk({p, " busy/done/err/valid"}, {busy, done, err, sig_valid}, 0);
        chk({p, " sig_data"}, sig_data, 0);
        chk({p, " word_cnt"}, word_cnt, 0);
    endtask

    typedef struct {
        logic [31:0] b;
        logic [31:0] e;
        int          n;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        int          lat, w, d0, n0, cnt;
        logic        got;
        logic [31:0] a0;
        vecs[0] = '{32'h8000_2000, 32'h8000_200C, 4};
        vecs[1] = '{32'h8000_2004, 32'h8000_2004, 1};
        vecs[2] = '{32'h8000_2010, 32'h8000_2000, 0};
        vecs[3] = '{32'h8000_2001, 32'h8000_2006, 2};
        vecs[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFF, 2};
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            d0 = ndone;
            kick(vecs[i].b, vecs[i].e);
            wait_done(lat, got);
            chk($sformatf("v%0d done", i), got, 1);
            chk($sformatf("v%0d done pulses", i), ndone - d0, 1);
            chk($sformatf("v%0d err", i), err, 0);
            chk($sformatf("v%0d word_cnt", i), word_cnt, vecs[i].n);
            chk($sformatf("v%0d requests", i), nreq, vecs[i].n);
            chk($sformatf("v%0d words out", i), out_q.size(), vecs[i].n);
            a0 = vecs[i].b & ~32'h3;
            for (int k = 0; k < vecs[i].n && k < out_q.size() && k < req_q.size(); k++) begin
                chk($sformatf("v%0d addr%0d", i, k), req_q[k], a0 + 32'(4 * k));
                chk($sformatf("v%0d data%0d", i, k), out_q[k], mem_word(a0 + 32'(4 * k)));
            end
            if (vecs[i].n == 0) chk($sformatf("v%0d empty latency<=2", i), lat <= 2, 1);
        end

        sig_ready = 1'b0;
        kick(32'h8000_2000, 32'h8000_2004);
        w = 0;
        while (!sig_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("s4 first valid", sig_valid, 1);
        n0 = nreq;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (sig_data !== 32'h0 || !sig_valid || dmem_in.mem_valid) cnt++;
        end
        chk("s4 stall hold violations", cnt, 0);
        chk("s4 no new request while stalled", nreq - n0, 0);
        sig_ready = 1'b1;
        wait_done(lat, got);
        chk("s4 done", got, 1);
        chk("s4 words out", out_q.size(), 2);
        if (out_q.size() == 2) chk("s4 order", {out_q[0], out_q[1]}, {32'h0, 32'h1});
        chk("s4 word_cnt", word_cnt, 2);

        stall_en = 1'b1;
        stall_at = 32'h0;
        d0 = ndone;
        kick(32'h8000_2000, 32'h8000_200C);
        cnt = 0;
        w = 0;
        while (!err && w < 40) begin
            if (dmem_in.mem_valid) cnt++;
            @(negedge clk);
            w++;
        end
        chk("s5 request cycles before err", cnt, 8);
        chk("s5 err", err, 1);
        chk("s5 mem_valid low", dmem_in.mem_valid, 0);
        chk("s5 busy low", busy, 0);
        repeat (5) @(negedge clk);
        chk("s5 err sticky", err, 1);
        chk("s5 no done", ndone - d0, 0);
        stall_en = 1'b0;
        kick(32'h8000_2004, 32'h8000_2004);
        chk("s5 restart clears err", err, 0);
        wait_done(lat, got);
        chk("s5 restart done", got, 1);
        chk("s5 restart word_cnt", word_cnt, 1);

        stall_en = 1'b1;
        stall_at = 32'h8000_2004;
        kick(32'h8000_2000, 32'h8000_200C);
        w = 0;
        while (!(word_cnt == 16'd1 && dmem_in.mem_valid) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("s6 second request pending", {dmem_in.mem_valid, word_cnt}, {1'b1, 16'd1});
        sig_begin = 32'h8000_3000;
        sig_end = 32'h8000_3010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("s6 start while busy addr", dmem_in.mem_addr, 32'h8000_2004);
        chk("s6 start while busy state", {busy, word_cnt}, {1'b1, 16'd1});
        d0 = ndone;
        mon_off = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk_idle("s6 after rst");
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (dmem_in.mem_valid || done || busy) cnt++;
        end
        chk("s6 stays idle after rst", cnt, 0);
        chk("s6 no done after rst", ndone - d0, 0);
        mon_off = 1'b0;
        stall_en = 1'b0;
        chk("handshake hold violations", hold_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
